// File: rtl/cpu_sequencer_if.sv
// Bus between the sequencer core and its program ROM / data memory.
// The core is the master: it drives addresses and strobes, and the ROM
// and memory return data. The ROM answers combinationally; the data
// memory answers one cycle after mem_rd.
interface cpu_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 12,
  parameter int MADDR_W = 8
);
  logic [PC_W-1:0]    rom_addr;
  logic [15:0]        rom_data;
  logic [MADDR_W-1:0] mem_addr;
  logic               mem_rd;
  logic               mem_wr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  modport master (
    output rom_addr,
    input  rom_data,
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for a 16-bit program ROM.
// Instruction word: [15:12] opcode, [11] register select (0 = A, 1 = B),
// [10:8] reserved, [7:0] data-memory address.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | out of reset, waiting for start
// FETCH  | IR <= ROM word at PC
// EXEC   | decode IR; issue memory strobe or update registers/flags
// LOADWB | memory read data returns; write it into A or B
// HALT   | stopped (EQUAL matched or invalid opcode); start restarts
//
// All bus outputs and status come from registered state, IR, A and B,
// so nothing combinational runs from rom_data or mem_rdata to an output.
module cpu_sequencer #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 12,
  parameter int MADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  cpu_sequencer_if.master   bus,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              equal,
  output logic              carry,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [3:0] OPC_OR    = 4'b0001;
  localparam logic [3:0] OPC_AND   = 4'b0010;
  localparam logic [3:0] OPC_LOAD  = 4'b0011;
  localparam logic [3:0] OPC_STORE = 4'b0100;
  localparam logic [3:0] OPC_EQUAL = 4'b0101;
  localparam logic [3:0] OPC_ADD   = 4'b1001;
  localparam logic [3:0] OPC_SUB   = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_LOADWB,
    S_HALT
  } state_t;

  state_t state;
  state_t next_state;

  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [3:0]        opc;
  logic              sel;
  logic [2:0]        unused_ir;

  // control strobes from the sequencing logic to the datapath
  logic pc_clr;
  logic pc_inc;
  logic ir_ld;
  logic flags_clr;
  logic alu_wr;
  logic eq_wr;
  logic err_set;
  logic ld_wb;
  logic mem_rd_c;
  logic mem_wr_c;

  // ALU results for the current IR
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign opc       = ir[15:12];
  assign sel       = ir[11];
  // reserved field of the instruction word carries no meaning
  assign unused_ir = ir[10:8];

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    next_state = state;
    pc_clr     = 1'b0;
    pc_inc     = 1'b0;
    ir_ld      = 1'b0;
    flags_clr  = 1'b0;
    alu_wr     = 1'b0;
    eq_wr      = 1'b0;
    err_set    = 1'b0;
    ld_wb      = 1'b0;
    mem_rd_c   = 1'b0;
    mem_wr_c   = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          next_state = S_FETCH;
          pc_clr     = 1'b1;
          flags_clr  = 1'b1;
        end
      end
      S_FETCH: begin
        ir_ld      = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        case (opc)
          OPC_LOAD: begin
            mem_rd_c   = 1'b1;
            next_state = S_LOADWB;
          end
          OPC_STORE: begin
            mem_wr_c   = 1'b1;
            pc_inc     = 1'b1;
            next_state = S_FETCH;
          end
          OPC_ADD, OPC_SUB, OPC_OR, OPC_AND: begin
            alu_wr     = 1'b1;
            pc_inc     = 1'b1;
            next_state = S_FETCH;
          end
          OPC_EQUAL: begin
            eq_wr = 1'b1;
            if (reg_a == reg_b) begin
              next_state = S_HALT;
            end else begin
              pc_inc     = 1'b1;
              next_state = S_FETCH;
            end
          end
          default: begin
            // PC stays on the offending instruction for post-mortem
            err_set    = 1'b1;
            next_state = S_HALT;
          end
        endcase
      end
      S_LOADWB: begin
        ld_wb      = 1'b1;
        pc_inc     = 1'b1;
        next_state = S_FETCH;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ALU: result always lands in B; carry is ADD carry-out or SUB borrow.
  always_comb begin
    sum       = {1'b0, reg_a} + {1'b0, reg_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opc)
      OPC_ADD: begin
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OPC_SUB: begin
        alu_res   = reg_a - reg_b;
        alu_carry = (reg_a < reg_b);
      end
      OPC_OR: begin
        alu_res = reg_a | reg_b;
      end
      OPC_AND: begin
        alu_res = reg_a & reg_b;
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Program counter and instruction register; PC wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (pc_clr) begin
        pc <= '0;
      end else if (pc_inc) begin
        pc <= pc + 1'b1;
      end
      if (ir_ld) begin
        ir <= bus.rom_data;
      end
    end
  end

  // Accumulators: ALU writes B, LOADWB writes the selected register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (alu_wr) begin
        reg_b <= alu_res;
      end
      if (ld_wb) begin
        if (sel) begin
          reg_b <= bus.mem_rdata;
        end else begin
          reg_a <= bus.mem_rdata;
        end
      end
    end
  end

  // Status flags; a fresh start clears them, EQUAL touches only equal.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      equal <= 1'b0;
      carry <= 1'b0;
      zero  <= 1'b0;
      error <= 1'b0;
    end else begin
      if (flags_clr) begin
        equal <= 1'b0;
        carry <= 1'b0;
        zero  <= 1'b0;
        error <= 1'b0;
      end
      if (alu_wr) begin
        carry <= alu_carry;
        zero  <= (alu_res == '0);
      end
      if (eq_wr) begin
        equal <= (reg_a == reg_b);
      end
      if (err_set) begin
        error <= 1'b1;
      end
    end
  end

  assign bus.rom_addr  = pc;
  assign bus.mem_addr  = ir[MADDR_W-1:0];
  assign bus.mem_rd    = mem_rd_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_wdata = sel ? reg_b : reg_a;

  assign busy = (state != S_IDLE) && (state != S_HALT);
  assign done = (state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level reference model predicts
// architectural state and the memory strobes of every cycle; directed
// programs plus hand-computed literal results pin that model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] reg_a, reg_b;
  logic       equal, carry, zero, busy, done, error;

  cpu_sequencer_if #(.DATA_W(8), .PC_W(12), .MADDR_W(8)) bus ();

  cpu_sequencer #(.DATA_W(8), .PC_W(12), .MADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .reg_a (reg_a),
    .reg_b (reg_b),
    .equal (equal),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // program ROM, bench data memory, and the model's own memory image
  logic [15:0] rom   [0:4095];
  logic [7:0]  mem   [0:255];
  logic [7:0]  m_mem [0:255];

  assign bus.rom_data = rom[bus.rom_addr];

  // observed writes and edge numbering
  int         edge_cnt = 0;
  int         start_edge = 0;
  int         q_edge [$];
  logic [7:0] q_addr [$];
  logic [7:0] q_data [$];

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      q_edge.push_back(edge_cnt);
      q_addr.push_back(bus.mem_addr);
      q_data.push_back(bus.mem_wdata);
    end
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    if (start && rst_n) start_edge <= edge_cnt;
    edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode = M_IDLE;
  int          m_phase = 0;
  bit          m_valid = 1'b0;
  logic [11:0] m_pc = '0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic        m_eq = 1'b0, m_c = 1'b0, m_z = 1'b0, m_err = 1'b0;

  function automatic int ilen(input logic [3:0] op);
    return (op == 4'b0011) ? 3 : 2;
  endfunction

  task automatic retire(input logic [15:0] w);
    int s;
    logic [7:0] ad;
    ad = w[7:0];
    case (w[15:12])
      4'd3: begin
        if (w[11]) m_b = m_mem[ad]; else m_a = m_mem[ad];
        m_pc = m_pc + 12'd1;
      end
      4'd4: begin
        m_mem[ad] = w[11] ? m_b : m_a;
        m_pc = m_pc + 12'd1;
      end
      4'd9: begin
        s = int'(m_a) + int'(m_b);
        m_b = 8'(s % 256);
        m_c = (s > 255);
        m_z = (m_b == 8'd0);
        m_pc = m_pc + 12'd1;
      end
      4'd10: begin
        m_c = (m_a < m_b);
        s = (int'(m_a) - int'(m_b) + 256) % 256;
        m_b = 8'(s);
        m_z = (m_b == 8'd0);
        m_pc = m_pc + 12'd1;
      end
      4'd1: begin
        m_b = m_a | m_b;
        m_c = 1'b0;
        m_z = (m_b == 8'd0);
        m_pc = m_pc + 12'd1;
      end
      4'd2: begin
        m_b = m_a & m_b;
        m_c = 1'b0;
        m_z = (m_b == 8'd0);
        m_pc = m_pc + 12'd1;
      end
      4'd5: begin
        m_eq = (m_a == m_b);
        if (m_eq) m_mode = M_HALT;
        else m_pc = m_pc + 12'd1;
      end
      default: begin
        m_err = 1'b1;
        m_mode = M_HALT;
      end
    endcase
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = M_IDLE; m_phase = 0; m_pc = '0; m_a = '0; m_b = '0;
        m_eq = 1'b0; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
        m_valid = 1'b1;
      end else if (m_mode != M_RUN) begin
        if (start) begin
          m_mode = M_RUN; m_phase = 0; m_pc = '0;
          m_eq = 1'b0; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
        end
      end else begin
        m_phase++;
        if (m_phase == ilen(rom[m_pc][15:12])) begin
          m_phase = 0;
          retire(rom[m_pc]);
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin : compare
    logic [15:0] w;
    logic        exp_rd, exp_wr;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        w = rom[m_pc];
        exp_rd = (m_mode == M_RUN) && (m_phase == 1) && (w[15:12] == 4'd3);
        exp_wr = (m_mode == M_RUN) && (m_phase == 1) && (w[15:12] == 4'd4);
        check("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
        check("reg_a", 32'(reg_a), 32'(m_a));
        check("reg_b", 32'(reg_b), 32'(m_b));
        check("busy_done_err_eq_c_z", 32'({busy, done, error, equal, carry, zero}),
              32'({m_mode == M_RUN, m_mode == M_HALT, m_err, m_eq, m_c, m_z}));
        check("mem_rd_wr", 32'({bus.mem_rd, bus.mem_wr}), 32'({exp_rd, exp_wr}));
        if (exp_rd || exp_wr) check("mem_addr", 32'(bus.mem_addr), 32'(w[7:0]));
        if (exp_wr) check("mem_wdata", 32'(bus.mem_wdata), 32'(w[11] ? m_b : m_a));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_mem(input int a, input logic [7:0] v);
    mem[a] = v;
    m_mem[a] = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_timeout: done not seen within %0d cycles, required done=1", name, max_cycles);
    end
  endtask

  task automatic clear_log();
    q_edge.delete();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic check_store(input string name, input int idx, input int a, input int d);
    if (q_addr.size() > idx) begin
      check({name, "_addr"}, 32'(q_addr[idx]), a);
      check({name, "_data"}, 32'(q_data[idx]), d);
    end else begin
      check({name, "_missing"}, 32'(q_addr.size()), idx + 1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;

    // reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pc", 32'(bus.rom_addr), 0);
    check("rst_a", 32'(reg_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD A 0 (reserved bits set) / LOAD B 1 / ADD / STORE B 15 / LOAD A 15 / EQUAL
    set_mem(0, 8'd3); set_mem(1, 8'd5);
    rom[0] = 16'h3700; rom[1] = 16'h3801; rom[2] = 16'h9000;
    rom[3] = 16'h480F; rom[4] = 16'h300F; rom[5] = 16'h5000;
    clear_log();
    pulse_start();
    wait_done(100, "add");
    check("add_b", 32'(reg_b), 8);
    check("add_carry", 32'(carry), 0);
    check("add_pc", 32'(bus.rom_addr), 5);
    check_store("add_st", 0, 15, 8);
    if (q_edge.size() > 0) check("add_wr_cycle", 32'(q_edge[0] - start_edge), 10);

    // SUB to zero, SUB with borrow, OR, AND, then invalid opcode
    set_mem(2, 8'd6);
    rom[0]  = 16'h3002; rom[1]  = 16'h3802; rom[2]  = 16'hA000; rom[3]  = 16'h4814;
    rom[4]  = 16'h3000; rom[5]  = 16'h3801; rom[6]  = 16'hA000; rom[7]  = 16'h4815;
    rom[8]  = 16'h3801; rom[9]  = 16'h1000; rom[10] = 16'h4816; rom[11] = 16'h2000;
    rom[12] = 16'hF000;
    clear_log();
    pulse_start();
    wait_done(200, "alu");
    check("alu_b", 32'(reg_b), 3);
    check("alu_zero", 32'(zero), 0);
    check("alu_carry", 32'(carry), 0);
    check("alu_error", 32'(error), 1);
    check("alu_pc", 32'(bus.rom_addr), 12);
    check_store("alu_sub0", 0, 20, 0);
    check_store("alu_sub1", 1, 21, 254);
    check_store("alu_or", 2, 22, 7);

    // 17-instruction demo; a start pulse mid-run must be ignored
    set_mem(0, 8'd3); set_mem(1, 8'd5); set_mem(2, 8'd1);
    rom[0]  = 16'h3000; rom[1]  = 16'h3801; rom[2]  = 16'h9000; rom[3]  = 16'h480F;
    rom[4]  = 16'h3800; rom[5]  = 16'hA000; rom[6]  = 16'h4810; rom[7]  = 16'h3801;
    rom[8]  = 16'h1000; rom[9]  = 16'h4811; rom[10] = 16'h3002; rom[11] = 16'h2000;
    rom[12] = 16'h4812; rom[13] = 16'h3001; rom[14] = 16'h5000; rom[15] = 16'h3801;
    rom[16] = 16'h5000;
    clear_log();
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(300, "demo");
    check("demo_pc", 32'(bus.rom_addr), 16);
    check("demo_equal", 32'(equal), 1);
    check("demo_done", 32'(done), 1);
    check("demo_error", 32'(error), 0);
    check("demo_nstores", 32'(q_addr.size()), 4);
    check_store("demo_st15", 0, 15, 8);
    check_store("demo_st16", 1, 16, 0);
    check_store("demo_st17", 2, 17, 7);
    check_store("demo_st18", 3, 18, 1);

    // invalid opcode at PC=2, busy start ignored, restart from HALT
    set_mem(0, 8'd3); set_mem(1, 8'd5);
    rom[0] = 16'h3000; rom[1] = 16'h3801; rom[2] = 16'h0000;
    pulse_start();
    pulse_start();
    wait_done(100, "inv");
    check("inv_error", 32'(error), 1);
    check("inv_pc", 32'(bus.rom_addr), 2);
    pulse_start();
    check("restart_error", 32'(error), 0);
    check("restart_busy", 32'(busy), 1);
    check("restart_pc", 32'(bus.rom_addr), 0);
    wait_done(100, "inv2");
    check("inv2_error", 32'(error), 1);

    // PC wrap: A=3, B=5 held; EQUALs until LOAD B at 4095, then EQUAL at 0 matches
    for (int i = 0; i < 4095; i++) rom[i] = 16'h5000;
    rom[4095] = 16'h3800;
    pulse_start();
    wait_done(9000, "wrap");
    check("wrap_pc", 32'(bus.rom_addr), 0);
    check("wrap_equal", 32'(equal), 1);
    check("wrap_b", 32'(reg_b), 3);

    // reset during LOADWB of LOAD A (A=0 beforehand)
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rom[0] = 16'h3000;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstwb_busy", 32'(busy), 0);
    check("rstwb_pc", 32'(bus.rom_addr), 0);
    check("rstwb_a", 32'(reg_a), 0);
    check("rstwb_mem_rd", 32'(bus.mem_rd), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
